alu_mc: RTL and testbench
=========================

# alu_mc

Parametrised multi-cycle ALU for the RISC datapath, successor to the single-cycle 2-bit-control ALU. Adds a WIDTH parameter, a 3-bit operation code that keeps the original four encodings, status flags, and an optional iterative shift-add multiplier. Sits between operand fetch and writeback. Both sides use valid/ready handshakes so the control unit can stall on multiply or on writeback backpressure.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits; legal range 2..64.

Ports:
- clk  input  1  single clock; every register updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- InValid  input  1  operand/opcode present this cycle.
- InReady  output  1  block will accept the operation on this edge.
- ALUInA  input  WIDTH  operand A.
- ALUInB  input  WIDTH  operand B.
- ALUControlSignal  input  3  operation code (see Operation).
- OutValid  output  1  result register holds an undelivered result.
- OutReady  input  1  consumer takes the result on this edge.
- ALUResult  output  WIDTH  registered result.
- Zero  output  1  registered; ALUResult == 0.
- Carry  output  1  registered; carry-out (ADD/SUB only).
- Overflow  output  1  registered; signed overflow for ADD/SUB, truncation for MUL.

Clocking and reset: one clock, clk. Reset is synchronous and active-high on reset.

## Operation
- Opcodes:
  - 000 AND, 001 OR, 010 ADD, 011 NAND (same encodings as the previous ALU).
  - 100 SUB (A + ~B + 1).
  - 101 XOR.
  - 110 SLT (signed A < B gives 1, else 0).
  - 111 MUL (unsigned, low WIDTH bits of the product).
- Accept rule: an op is accepted when InValid && InReady on a rising edge.
- InReady = !reset && state==IDLE && (!OutValid || OutReady).
- Result register is single-entry; a result being drained and a new single-cycle result may be loaded on the same edge.
- FSM states:
  - IDLE: single-cycle ops load the result register on the accept edge. Accepting MUL latches A, B, zeroes the accumulator, sets Count=WIDTH and goes to MUL.
  - MUL: one shift-add iteration per cycle. Product is 2*WIDTH bits internally. Count decrements each cycle. When Count reaches 1, the next edge loads the result register, sets OutValid=1 and returns to IDLE.
- Flags:
  - Zero is computed for every op.
  - Carry = bit WIDTH of the (WIDTH+1)-bit sum for ADD/SUB; 0 for all other ops.
  - Overflow = (sign A == sign of effective B) && (sign of result != sign A) for ADD/SUB. For MUL it is |product[2W-1:W]|. It is 0 for all other ops.
- OutValid clears on an edge with OutReady=1 unless a new result loads on that edge.
- Undefined opcodes: none; all eight are defined.

## Timing
- Reset values: OutValid=0, ALUResult=0, Zero=0, Carry=0, Overflow=0, state=IDLE, Count=0. InReady=0 while reset is high.
- Single-cycle op latency: accepted at edge N, OutValid=1 after edge N; throughput 1/cycle with OutReady held high.
- MUL latency: accepted at edge N, OutValid=1 after edge N+WIDTH. InReady=0 for those WIDTH cycles.
- Backpressure: while OutValid=1 and OutReady=0, InReady=0 and ALUResult and all flags hold stable.
- Simultaneous drain and accept: the old result is consumed and the new result loads on the same edge; OutValid stays 1.
- Reset mid-MUL: the product is discarded, the FSM returns to IDLE, and no result is produced.
- InValid while InReady=0: ignored; upstream holds the operands.

## Configuration
- ALU_MUL_EN defined: the multiplier, the MUL state and Count are compiled in, behaving as above.
- ALU_MUL_EN undefined: no multiplier hardware and the FSM never leaves IDLE. Opcode 111 completes as a single-cycle op with ALUResult=0, Zero=1, Carry=0, Overflow=0.

## Test plan
All scenarios use WIDTH=32.
- ADD A=0xFFFFFFFF, B=0x00000001 -> ALUResult=0x00000000, Zero=1, Carry=1, Overflow=0, OutValid one cycle after accept.
- SUB A=0x80000000, B=0x00000001 -> 0x7FFFFFFF, Overflow=1, Carry=1. SLT A=0xFFFFFFFF, B=0x00000001 -> 0x00000001.
- MUL A=7, B=6 (ALU_MUL_EN defined) -> InReady=0 for 32 cycles, then ALUResult=42, Overflow=0. MUL A=0x00010000, B=0x00010000 -> ALUResult=0, Zero=1, Overflow=1.
- Back-to-back ADD ops with OutReady held low -> first result is held stable, second op is not accepted (InReady=0). Raising OutReady drains the first result and accepts the second on the same edge.
- Assert reset for one cycle, 10 cycles into a MUL -> OutValid=0, all outputs 0, InReady=1 the cycle after reset deasserts, no stale result appears.
- ALU_MUL_EN undefined, opcode 111 with A=7, B=6 -> ALUResult=0, Zero=1, OutValid one cycle after accept.

Source files
------------

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes, registered result and status flags.
// Define ALU_MUL_EN to build the iterative shift-add multiplier for opcode 111.
module alu_mc #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             InValid,
   output logic             InReady,
   input  logic [WIDTH-1:0] ALUInA,
   input  logic [WIDTH-1:0] ALUInB,
   input  logic [2:0]       ALUControlSignal,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [WIDTH-1:0] ALUResult,
   output logic             Zero,
   output logic             Carry,
   output logic             Overflow
);

   localparam logic [2:0] OpAnd  = 3'b000;
   localparam logic [2:0] OpOr   = 3'b001;
   localparam logic [2:0] OpAdd  = 3'b010;
   localparam logic [2:0] OpNand = 3'b011;
   localparam logic [2:0] OpSub  = 3'b100;
   localparam logic [2:0] OpXor  = 3'b101;
   localparam logic [2:0] OpSlt  = 3'b110;
   localparam logic [2:0] OpMul  = 3'b111;

   logic             is_sub;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c;
   logic             alu_v;

   logic             accept;
   logic             load;
   logic [WIDTH-1:0] load_res;
   logic             load_c;
   logic             load_v;

   logic             out_valid_q;
   logic [WIDTH-1:0] result_q;
   logic             zero_q;
   logic             carry_q;
   logic             overflow_q;

   // SUB shares the adder as A + ~B + 1.
   always_comb begin
      is_sub  = (ALUControlSignal == OpSub);
      b_eff   = is_sub ? ~ALUInB : ALUInB;
      sum     = {1'b0, ALUInA} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (ALUControlSignal)
         OpAnd:  alu_res = ALUInA & ALUInB;
         OpOr:   alu_res = ALUInA | ALUInB;
         OpNand: alu_res = ~(ALUInA & ALUInB);
         OpXor:  alu_res = ALUInA ^ ALUInB;
         OpSlt:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(ALUInA) < $signed(ALUInB))};
         OpAdd, OpSub: begin
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = (ALUInA[WIDTH-1] == b_eff[WIDTH-1]) &&
                      (sum[WIDTH-1] != ALUInA[WIDTH-1]);
         end
         default: alu_res = '0;
      endcase
   end

   assign accept = InValid && InReady;

`ifdef ALU_MUL_EN
   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam logic [0:0] StIdle = 1'b0;
   localparam logic [0:0] StMul  = 1'b1;

   logic [0:0]         state_q;
   logic [CW-1:0]      count_q;
   logic [2*WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0]   mplier_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] acc_next;
   logic               mul_done;
   logic               start_mul;

   assign acc_next  = mplier_q[0] ? acc_q + mcand_q : acc_q;
   assign mul_done  = (state_q == StMul) && (count_q == CW'(1));
   assign start_mul = accept && (ALUControlSignal == OpMul);
   assign load      = (accept && (ALUControlSignal != OpMul)) || mul_done;
   assign load_res  = mul_done ? acc_next[WIDTH-1:0] : alu_res;
   assign load_c    = mul_done ? 1'b0 : alu_c;
   assign load_v    = mul_done ? |acc_next[2*WIDTH-1:WIDTH] : alu_v;
   assign InReady   = !reset && (state_q == StIdle) && (!out_valid_q || OutReady);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         count_q  <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
      end else if (start_mul) begin
         state_q  <= StMul;
         count_q  <= CW'(WIDTH);
         mcand_q  <= {{WIDTH{1'b0}}, ALUInA};
         mplier_q <= ALUInB;
         acc_q    <= '0;
      end else if (state_q == StMul) begin
         acc_q    <= acc_next;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         count_q  <= count_q - CW'(1);
         if (count_q == CW'(1)) state_q <= StIdle;
      end
   end
`else
   // Opcode 111 completes in one cycle with an all-zero result.
   assign load     = accept;
   assign load_res = alu_res;
   assign load_c   = alu_c;
   assign load_v   = alu_v;
   assign InReady  = !reset && (!out_valid_q || OutReady);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
         zero_q      <= 1'b0;
         carry_q     <= 1'b0;
         overflow_q  <= 1'b0;
      end else if (load) begin
         out_valid_q <= 1'b1;
         result_q    <= load_res;
         zero_q      <= (load_res == '0);
         carry_q     <= load_c;
         overflow_q  <= load_v;
      end else if (OutReady) begin
         out_valid_q <= 1'b0;
      end
   end

   assign OutValid  = out_valid_q;
   assign ALUResult = result_q;
   assign Zero      = zero_q;
   assign Carry     = carry_q;
   assign Overflow  = overflow_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed corner cases plus randomized ops
// against an arithmetic reference model; honours ALU_MUL_EN like the design.
module tb_alu_mc;

   localparam int unsigned W = 32;
`ifdef ALU_MUL_EN
   localparam bit MulEn = 1'b1;
`else
   localparam bit MulEn = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          InValid;
   logic          InReady;
   logic [W-1:0]  ALUInA;
   logic [W-1:0]  ALUInB;
   logic [2:0]    ALUControlSignal;
   logic          OutValid;
   logic          OutReady;
   logic [W-1:0]  ALUResult;
   logic          Zero;
   logic          Carry;
   logic          Overflow;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_mc #(.WIDTH(W)) dut (
      .clk              (clk),
      .reset            (reset),
      .InValid          (InValid),
      .InReady          (InReady),
      .ALUInA           (ALUInA),
      .ALUInB           (ALUInB),
      .ALUControlSignal (ALUControlSignal),
      .OutValid         (OutValid),
      .OutReady         (OutReady),
      .ALUResult        (ALUResult),
      .Zero             (Zero),
      .Carry            (Carry),
      .Overflow         (Overflow)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operand values.
   function automatic void model(input logic [2:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, output logic [W-1:0] r,
                                 output logic z, output logic c, output logic v);
      longint          sa = longint'($signed(a));
      longint          sb = longint'($signed(b));
      longint          s;
      longint unsigned p;
      r = '0; c = 1'b0; v = 1'b0;
      case (op)
         3'd0: r = a & b;
         3'd1: r = a | b;
         3'd2: begin
            p = longint'(a) + longint'(b);
            r = p[31:0];
            c = p[32];
            s = sa + sb;
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         3'd3: r = ~(a & b);
         3'd4: begin
            r = a - b;
            c = (a >= b);
            s = sa - sb;
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         3'd5: r = a ^ b;
         3'd6: r = (sa < sb) ? 32'd1 : 32'd0;
         default: begin
            if (MulEn) begin
               p = longint'(a) * longint'(b);
               r = p[31:0];
               v = (p[63:32] != 32'd0);
            end
         end
      endcase
      z = (r == '0);
   endfunction

   // Present an op at a negedge and return at the negedge after it was accepted.
   task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      int n = 0;
      ALUControlSignal = op;
      ALUInA  = a;
      ALUInB  = b;
      InValid = 1'b1;
      #1;
      while (InReady !== 1'b1 && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("accept_wait", {63'd0, InReady}, 64'd1);
      @(posedge clk);
      @(negedge clk);
      InValid = 1'b0;
   endtask

   task automatic do_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b);
      logic [W-1:0] er;
      logic         ez, ec, ev;
      int           cyc = 0;
      int           rdy = 0;
      model(op, a, b, er, ez, ec, ev);
      OutReady = 1'b1;
      send(op, a, b);
      while (OutValid !== 1'b1 && cyc < 200) begin
         if (InReady) rdy++;
         @(negedge clk);
         cyc++;
      end
      chk($sformatf("%s.latency", tag), 64'(cyc), (MulEn && op == 3'd7) ? 64'(W) : 64'd0);
      if (MulEn && op == 3'd7) chk($sformatf("%s.busy_ready", tag), 64'(rdy), 64'd0);
      chk($sformatf("%s.result", tag), {32'd0, ALUResult}, {32'd0, er});
      chk($sformatf("%s.zero", tag), {63'd0, Zero}, {63'd0, ez});
      chk($sformatf("%s.carry", tag), {63'd0, Carry}, {63'd0, ec});
      chk($sformatf("%s.overflow", tag), {63'd0, Overflow}, {63'd0, ev});
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int stale;
      reset = 1'b1; InValid = 1'b0; OutReady = 1'b0;
      ALUInA = '0; ALUInB = '0; ALUControlSignal = 3'd0;
      repeat (2) @(negedge clk);
      chk("rst.in_ready", {63'd0, InReady}, 64'd0);
      chk("rst.out_valid", {63'd0, OutValid}, 64'd0);
      chk("rst.result", {32'd0, ALUResult}, 64'd0);
      chk("rst.flags", {61'd0, Zero, Carry, Overflow}, 64'd0);
      reset = 1'b0;
      #1;
      chk("rst.ready_after", {63'd0, InReady}, 64'd1);

      do_op("add_wrap", 3'd2, 32'hFFFF_FFFF, 32'h0000_0001);
      do_op("sub_ovf", 3'd4, 32'h8000_0000, 32'h0000_0001);
      do_op("slt_neg", 3'd6, 32'hFFFF_FFFF, 32'h0000_0001);
      do_op("mul_small", 3'd7, 32'd7, 32'd6);
      do_op("mul_trunc", 3'd7, 32'h0001_0000, 32'h0001_0000);
      do_op("and", 3'd0, 32'hF0F0_1234, 32'h0FF0_FF00);
      do_op("or", 3'd1, 32'hF000_0001, 32'h0000_1000);
      do_op("nand", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      do_op("xor", 3'd5, 32'hA5A5_A5A5, 32'h5A5A_5A5A);
      do_op("sub_minneg", 3'd4, 32'h0000_0005, 32'h8000_0000);

      for (int i = 0; i < 60; i++) begin
         do_op($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), pick(), pick());
      end

      // Backpressure: first result held, second op waits, then drain+accept on one edge.
      @(negedge clk);
      OutReady = 1'b0;
      send(3'd2, 32'd5, 32'd6);
      chk("bp.first_valid", {63'd0, OutValid}, 64'd1);
      ALUControlSignal = 3'd2; ALUInA = 32'h100; ALUInB = 32'h200; InValid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("bp.in_ready_low", {63'd0, InReady}, 64'd0);
         chk("bp.result_hold", {32'd0, ALUResult}, 64'd11);
         @(negedge clk);
      end
      OutReady = 1'b1;
      #1;
      chk("bp.in_ready_high", {63'd0, InReady}, 64'd1);
      @(posedge clk);
      @(negedge clk);
      InValid = 1'b0;
      chk("bp.second_valid", {63'd0, OutValid}, 64'd1);
      chk("bp.second_result", {32'd0, ALUResult}, 64'h300);
      @(negedge clk);
      chk("bp.drained", {63'd0, OutValid}, 64'd0);

      // Reset ten cycles into a multiply: nothing may come out afterwards.
      OutReady = 1'b0;
      send(3'd7, 32'd7, 32'd6);
      repeat (10) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("mrst.in_ready_in_reset", {63'd0, InReady}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("mrst.out_valid", {63'd0, OutValid}, 64'd0);
      chk("mrst.result", {32'd0, ALUResult}, 64'd0);
      chk("mrst.flags", {61'd0, Zero, Carry, Overflow}, 64'd0);
      chk("mrst.in_ready", {63'd0, InReady}, 64'd1);
      OutReady = 1'b1;
      stale = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (OutValid !== 1'b0) stale++;
      end
      chk("mrst.no_stale", 64'(stale), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
